// File: rtl/alu_share_arbiter_if.sv
// Signal bundle between the two issue ports, the shared ALU/flags datapath and the arbiter.
// Defining ALU_ARB_STICKY_EN adds the per-requester sticky {carry,overflow} signals.
interface alu_share_arbiter_if #(
    parameter int WIDTH = 32
);
    // Request handshake: a transfer happens at a rising edge where valid & ready are both 1;
    // while valid is high and ready is low the requester holds a/b/sel stable.
    logic             req0_valid;
    logic             req0_ready;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic [3:0]       req0_sel;
    logic             req1_valid;
    logic             req1_ready;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;
    logic [3:0]       req1_sel;

    logic             alu_issue;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [3:0]       alu_sel;
    logic [WIDTH-1:0] alu_result;
    logic [4:0]       alu_flags;

    logic             rsp0_valid;
    logic [WIDTH-1:0] rsp0_result;
    logic [4:0]       rsp0_flags;
    logic             rsp1_valid;
    logic [WIDTH-1:0] rsp1_result;
    logic [4:0]       rsp1_flags;
`ifdef ALU_ARB_STICKY_EN
    logic             sticky0_clr;
    logic             sticky1_clr;
    logic [1:0]       sticky0;
    logic [1:0]       sticky1;
`endif

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_sel,
        input  req1_valid, req1_a, req1_b, req1_sel,
        output req0_ready, req1_ready,
        output alu_issue, alu_a, alu_b, alu_sel,
        input  alu_result, alu_flags,
        output rsp0_valid, rsp0_result, rsp0_flags,
        output rsp1_valid, rsp1_result, rsp1_flags
`ifdef ALU_ARB_STICKY_EN
        ,
        input  sticky0_clr, sticky1_clr,
        output sticky0, sticky1
`endif
    );

    modport master (
        output req0_valid, req0_a, req0_b, req0_sel,
        output req1_valid, req1_a, req1_b, req1_sel,
        input  req0_ready, req1_ready,
        input  alu_issue, alu_a, alu_b, alu_sel,
        output alu_result, alu_flags,
        input  rsp0_valid, rsp0_result, rsp0_flags,
        input  rsp1_valid, rsp1_result, rsp1_flags
`ifdef ALU_ARB_STICKY_EN
        ,
        output sticky0_clr, sticky1_clr,
        input  sticky0, sticky1
`endif
    );
endinterface

// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one ALU + flags unit between two requesters, with response routing.
// Optional feature macro: ALU_ARB_STICKY_EN (sticky {carry,overflow} accumulators per requester).
module alu_share_arbiter #(
    parameter int WIDTH   = 32,
    parameter int ALU_LAT = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    alu_share_arbiter_if.slave bus_io
);

    logic               ready0;
    logic               ready1;
    logic               hs_any;
    logic               hs_id;
    logic               last_q, last_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [3:0]         sel_q, sel_d;
    logic [ALU_LAT-1:0] tag_v_q, tag_v_d;
    logic [ALU_LAT-1:0] tag_id_q, tag_id_d;
    logic               done;
    logic               done_id;
    logic               rsp0_v_q, rsp0_v_d;
    logic               rsp1_v_q, rsp1_v_d;
    logic [WIDTH-1:0]   rsp0_res_q, rsp0_res_d;
    logic [WIDTH-1:0]   rsp1_res_q, rsp1_res_d;
    logic [4:0]         rsp0_fl_q, rsp0_fl_d;
    logic [4:0]         rsp1_fl_q, rsp1_fl_d;

    // last_q holds the id granted most recently; it resets to 1 so req0 wins the first tie.
    always_comb begin
        ready0 = rst_n & bus_io.req0_valid & (~bus_io.req1_valid | last_q);
        ready1 = rst_n & bus_io.req1_valid & (~bus_io.req0_valid | ~last_q);
        hs_any = ready0 | ready1;
        hs_id  = ready1;
        last_d = hs_any ? hs_id : last_q;

        a_d   = a_q;
        b_d   = b_q;
        sel_d = sel_q;
        if (hs_any) begin
            a_d   = hs_id ? bus_io.req1_a   : bus_io.req0_a;
            b_d   = hs_id ? bus_io.req1_b   : bus_io.req0_b;
            sel_d = hs_id ? bus_io.req1_sel : bus_io.req0_sel;
        end

        tag_v_d     = '0;
        tag_id_d    = '0;
        tag_v_d[0]  = hs_any;
        tag_id_d[0] = hs_id;
        for (int k = 1; k < ALU_LAT; k++) begin
            tag_v_d[k]  = tag_v_q[k-1];
            tag_id_d[k] = tag_id_q[k-1];
        end

        // The oldest tag marks the edge at which the ALU output belongs to that requester.
        done     = tag_v_q[ALU_LAT-1];
        done_id  = tag_id_q[ALU_LAT-1];
        rsp0_v_d = done & ~done_id;
        rsp1_v_d = done & done_id;

        rsp0_res_d = rsp0_res_q;
        rsp0_fl_d  = rsp0_fl_q;
        rsp1_res_d = rsp1_res_q;
        rsp1_fl_d  = rsp1_fl_q;
        if (rsp0_v_d) begin
            rsp0_res_d = bus_io.alu_result;
            rsp0_fl_d  = bus_io.alu_flags;
        end
        if (rsp1_v_d) begin
            rsp1_res_d = bus_io.alu_result;
            rsp1_fl_d  = bus_io.alu_flags;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q     <= 1'b1;
            a_q        <= '0;
            b_q        <= '0;
            sel_q      <= '0;
            tag_v_q    <= '0;
            tag_id_q   <= '0;
            rsp0_v_q   <= 1'b0;
            rsp1_v_q   <= 1'b0;
            rsp0_res_q <= '0;
            rsp1_res_q <= '0;
            rsp0_fl_q  <= '0;
            rsp1_fl_q  <= '0;
        end else begin
            last_q     <= last_d;
            a_q        <= a_d;
            b_q        <= b_d;
            sel_q      <= sel_d;
            tag_v_q    <= tag_v_d;
            tag_id_q   <= tag_id_d;
            rsp0_v_q   <= rsp0_v_d;
            rsp1_v_q   <= rsp1_v_d;
            rsp0_res_q <= rsp0_res_d;
            rsp1_res_q <= rsp1_res_d;
            rsp0_fl_q  <= rsp0_fl_d;
            rsp1_fl_q  <= rsp1_fl_d;
        end
    end

    assign bus_io.req0_ready  = ready0;
    assign bus_io.req1_ready  = ready1;
    assign bus_io.alu_issue   = tag_v_q[0];
    assign bus_io.alu_a       = a_q;
    assign bus_io.alu_b       = b_q;
    assign bus_io.alu_sel     = sel_q;
    assign bus_io.rsp0_valid  = rsp0_v_q;
    assign bus_io.rsp0_result = rsp0_res_q;
    assign bus_io.rsp0_flags  = rsp0_fl_q;
    assign bus_io.rsp1_valid  = rsp1_v_q;
    assign bus_io.rsp1_result = rsp1_res_q;
    assign bus_io.rsp1_flags  = rsp1_fl_q;

`ifdef ALU_ARB_STICKY_EN
    logic [1:0] sticky0_q, sticky0_d;
    logic [1:0] sticky1_q, sticky1_d;

    // Clear is applied before the arriving response's {carry,overflow} bits are merged.
    always_comb begin
        sticky0_d = bus_io.sticky0_clr ? 2'b00 : sticky0_q;
        sticky1_d = bus_io.sticky1_clr ? 2'b00 : sticky1_q;
        if (rsp0_v_d) sticky0_d = sticky0_d | bus_io.alu_flags[4:3];
        if (rsp1_v_d) sticky1_d = sticky1_d | bus_io.alu_flags[4:3];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky0_q <= 2'b00;
            sticky1_q <= 2'b00;
        end else begin
            sticky0_q <= sticky0_d;
            sticky1_q <= sticky1_d;
        end
    end

    assign bus_io.sticky0 = sticky0_q;
    assign bus_io.sticky1 = sticky1_q;
`endif

endmodule
